alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 8-bit combinational ALU between two independent requesters. Each operation is accepted with a valid/ready handshake, its opcode and operands are registered and presented to the ALU for one execute cycle, and the result and zero flag are returned on a response channel tagged with the requester ID. It sits between the operation sources and the ALU instance. It passes the 4-bit opcode through without decoding it.

---
 rtl/alu_arbiter.sv | 102 ++++++++++
 tb/tb_alu_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter/sequencer sharing one combinational 8-bit ALU
// between two requesters.
//
// Each accepted operation is registered onto alu_op/alu_a/alu_b, given one
// execute cycle, and its result/zero flag are returned on a response channel
// tagged with the requester ID.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   req{0,1}_valid/ready      operation handshake per requester
//   req{0,1}_op/_a/_b         opcode and operands per requester
//   alu_op, alu_a, alu_b      registered operation presented to the ALU
//   alu_result, alu_zero      ALU outputs, captured at the end of the execute cycle
//   rsp_valid/ready           response handshake
//   rsp_id, rsp_data, rsp_zero  owner, captured result and zero flag
//   busy                      high whenever an operation is in flight
module alu_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e state_q;
  logic   last_grant_q;
  logic   idle;
  logic   grant_id;

  // Grant decision. The rst term keeps both readies low while reset is held,
  // even though the state register already reads IDLE.
  always_comb begin
    idle       = (state_q == StIdle) && !rst;
    grant_id   = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    req0_ready = idle && req0_valid && !grant_id;
    req1_ready = idle && req1_valid && grant_id;
  end

  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;  // requester 0 wins the first contention
      alu_op       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
      rsp_zero     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req0_valid || req1_valid) begin
            alu_op       <= grant_id ? req1_op : req0_op;
            alu_a        <= grant_id ? req1_a  : req0_a;
            alu_b        <= grant_id ? req1_b  : req0_b;
            rsp_id       <= grant_id;
            last_grant_q <= grant_id;
            state_q      <= StExec;
          end
        end
        StExec: begin
          rsp_data <= alu_result;
          rsp_zero <= alu_zero;
          state_q  <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus randomized traffic, all
// checked against a transaction-level model (one operation in flight, response
// visible two cycles after accept, round-robin grant on contention).
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_op = '0, req1_op = '0;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       alu_zero;
  logic       rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_zero, busy;
  logic [7:0] rsp_data;

  always #5 clk = ~clk;

  // Bench ALU: addition.
  assign alu_result = alu_a + alu_b;
  assign alu_zero   = (alu_result == 8'h00);

  alu_arbiter #(.DATA_W(8), .OP_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Transaction-level reference model.
  logic       m_pend = 1'b0;   // an operation is in flight
  int         m_age  = 0;      // edges since its accept
  logic       m_last = 1'b1;   // most recent grant
  logic       m_id;
  logic [3:0] m_op;
  logic [7:0] m_a, m_b, m_res;
  logic       acc0 = 1'b0, acc1 = 1'b0;  // accepts on the edge that ended the last step

  // One clock cycle. Entered and left #1 after a rising edge with inputs already driven.
  task automatic step();
    logic v0, v1, gid, ev;
    @(negedge clk);
    v0   = req0_valid;
    v1   = req1_valid;
    gid  = (v0 && v1) ? ~m_last : v1;
    acc0 = !m_pend && v0 && !gid;
    acc1 = !m_pend && v1 && gid;
    ev   = m_pend && (m_age >= 2);
    check_val("req0_ready", {31'b0, req0_ready}, {31'b0, acc0});
    check_val("req1_ready", {31'b0, req1_ready}, {31'b0, acc1});
    check_val("rsp_valid", {31'b0, rsp_valid}, {31'b0, ev});
    check_val("busy", {31'b0, busy}, {31'b0, m_pend});
    if (m_pend && m_age == 1) begin
      check_val("alu_op", {28'b0, alu_op}, {28'b0, m_op});
      check_val("alu_a", {24'b0, alu_a}, {24'b0, m_a});
      check_val("alu_b", {24'b0, alu_b}, {24'b0, m_b});
    end
    if (ev) begin
      check_val("rsp_id", {31'b0, rsp_id}, {31'b0, m_id});
      check_val("rsp_data", {24'b0, rsp_data}, {24'b0, m_res});
      check_val("rsp_zero", {31'b0, rsp_zero}, {31'b0, (m_res == 8'h00)});
    end
    if (m_pend) begin
      if (ev && rsp_ready) m_pend = 1'b0;
      else m_age++;
    end else if (acc0 || acc1) begin
      m_pend = 1'b1;
      m_age  = 1;
      m_last = gid;
      m_id   = gid;
      m_op   = gid ? req1_op : req0_op;
      m_a    = gid ? req1_a : req0_a;
      m_b    = gid ? req1_b : req0_b;
      m_res  = m_a + m_b;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asserts reset mid-cycle, checks outputs immediately, releases after an edge.
  task automatic do_reset();
    #3 rst = 1'b1;
    #1;
    check_val("rst_alu_op", {28'b0, alu_op}, 32'h0);
    check_val("rst_alu_a", {24'b0, alu_a}, 32'h0);
    check_val("rst_alu_b", {24'b0, alu_b}, 32'h0);
    check_val("rst_rsp_id", {31'b0, rsp_id}, 32'h0);
    check_val("rst_rsp_data", {24'b0, rsp_data}, 32'h0);
    check_val("rst_rsp_zero", {31'b0, rsp_zero}, 32'h0);
    check_val("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check_val("rst_req0_ready", {31'b0, req0_ready}, 32'h0);
    check_val("rst_req1_ready", {31'b0, req1_ready}, 32'h0);
    check_val("rst_busy", {31'b0, busy}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_pend = 1'b0;
    m_age  = 0;
    m_last = 1'b1;
    acc0   = 1'b0;
    acc1   = 1'b0;
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 20 && m_pend; i++) step();
    check_val("drain_timeout", {31'b0, m_pend}, 32'h0);
  endtask

  // Single req0 operation with explicit latency checks.
  task automatic single_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
    int waited = 0;
    req0_op    = 4'h3;
    req0_a     = a;
    req0_b     = b;
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    do begin
      step();
      waited++;
    end while (!acc0 && waited < 10);
    check_val("single_accept", {31'b0, acc0}, 32'h1);
    req0_valid = 1'b0;
    check_val("single_n1_busy", {31'b0, busy}, 32'h1);
    check_val("single_n1_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    step();
    check_val("single_n2_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    check_val("single_n2_busy", {31'b0, busy}, 32'h1);
    check_val("single_rsp_id", {31'b0, rsp_id}, 32'h0);
    check_val("single_rsp_data", {24'b0, rsp_data}, {24'b0, exp});
    check_val("single_rsp_zero", {31'b0, rsp_zero}, {31'b0, (exp == 8'h00)});
    step();
  endtask

  task automatic drive_random();
    if (!req0_valid || acc0) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req0_op    = 4'($urandom);
      req0_a     = 8'($urandom);
      req0_b     = ($urandom_range(0, 3) == 0) ? 8'(~req0_a + 8'd1) : 8'($urandom);
    end
    if (!req1_valid || acc1) begin
      req1_valid = ($urandom_range(0, 2) != 0);
      req1_op    = 4'($urandom);
      req1_a     = 8'($urandom);
      req1_b     = ($urandom_range(0, 3) == 0) ? 8'(~req1_a + 8'd1) : 8'($urandom);
    end
    rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    int k;
    int last_c;
    int c;
    int n_str;
    int waited;

    // Reset and single operation.
    @(posedge clk);
    #1;
    do_reset();
    single_op(8'h05, 8'h03, 8'h08);
    drain();

    // Contention from reset: strict alternation 0,1,0,1.
    req0_op = 4'h1; req0_a = 8'h12; req0_b = 8'h34; req0_valid = 1'b1;
    req1_op = 4'h2; req1_a = 8'hFF; req1_b = 8'h01; req1_valid = 1'b1;
    rsp_ready = 1'b1;
    do_reset();
    k = 0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      step();
      if (acc0 || acc1) begin
        check_val("rr_order", {31'b0, acc1}, k % 2);
        k++;
      end
    end
    check_val("rr_grants", k, 4);
    drain();

    // Back-pressure: four stalled cycles in RESP with req1 waiting.
    req0_op = 4'h5; req0_a = 8'h40; req0_b = 8'h02; req0_valid = 1'b1;
    rsp_ready = 1'b0;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!acc0 && waited < 10);
    check_val("bp_accept", {31'b0, acc0}, 32'h1);
    req0_valid = 1'b0;
    req1_op = 4'h6; req1_a = 8'h10; req1_b = 8'h20; req1_valid = 1'b1;
    step();
    repeat (4) step();
    rsp_ready = 1'b1;
    step();
    step();
    check_val("bp_grant_after_stall", {31'b0, acc1}, 32'h1);
    drain();

    // Single requester streaming: req1 every 3 cycles.
    req1_valid = 1'b1;
    rsp_ready  = 1'b1;
    last_c = -1;
    n_str  = 0;
    for (int i = 0; i < 16; i++) begin
      c = cyc;
      step();
      if (acc1) begin
        if (last_c >= 0) check_val("stream_interval", c - last_c, 3);
        last_c = c;
        n_str++;
        req1_a = 8'($urandom);
        req1_b = 8'($urandom);
      end
    end
    check_val("stream_grants", {31'b0, (n_str >= 5)}, 32'h1);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive_random();
      step();
    end
    drain();

    // Reset during EXEC discards the operation.
    req0_op = 4'h7; req0_a = 8'h21; req0_b = 8'h22; req0_valid = 1'b1;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!acc0 && waited < 10);
    check_val("exec_rst_accept", {31'b0, acc0}, 32'h1);
    req0_valid = 1'b0;
    do_reset();
    repeat (4) step();
    single_op(8'h05, 8'h03, 8'h08);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
